// File: rtl/shift_arbiter.sv
// shift_arbiter: arbitrates two requesters onto one external registered shifter and returns the result.
// Latency: rsp_valid rises in the cycle after acceptance edge + 2, for legal and illegal ops alike.
// Backpressure: one op in flight; both request readies low while busy; response held until rsp_ready.
// Optional feature: define SHIFT_ARB_RR_EN for round-robin arbitration (default is fixed priority, req0 wins).
module shift_arbiter (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_op,
  input  logic [31:0] req0_dat1,
  input  logic [31:0] req0_dat2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req1_dat1,
  input  logic [31:0] req1_dat2,
  output logic        sh_dat_ready,
  output logic [31:0] sh_dat1,
  output logic [31:0] sh_dat2,
  output logic [4:0]  sh_instr,
  input  logic [31:0] sh_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [31:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] dat1_q, dat1_d;
  logic [31:0] dat2_q, dat2_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        last_grant_q, last_grant_d;

  logic        grant;
  logic        accept;
  logic [4:0]  sel_op;
  logic        sel_legal;

  // Pick which requester would be accepted this cycle (index 0 or 1).
  always_comb begin
    grant = 1'b0;
`ifdef SHIFT_ARB_RR_EN
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
`else
    grant = ~req0_valid & req1_valid;
`endif
  end

  // Ready only in IDLE for the granted, valid requester; gated by reset so outputs drop asynchronously.
  always_comb begin
    req0_ready = reset && (state_q == IDLE) && !grant && req0_valid;
    req1_ready = reset && (state_q == IDLE) &&  grant && req1_valid;
    accept     = req0_ready || req1_ready;
    sel_op     = grant ? req1_op : req0_op;
    sel_legal  = (sel_op == 5'd8) || (sel_op == 5'd12) || (sel_op == 5'd13);
  end

  // Next-state and latch updates for the IDLE -> ISSUE -> CAPTURE -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dat1_d       = dat1_q;
    dat2_d       = dat2_q;
    id_d         = id_q;
    err_d        = err_q;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = ISSUE;
          op_d         = sel_op;
          dat1_d       = grant ? req1_dat1 : req0_dat1;
          dat2_d       = grant ? req1_dat2 : req0_dat2;
          id_d         = grant;
          err_d        = !sel_legal;
          last_grant_d = grant;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        // Shifter result is registered, so it is valid one cycle after the strobe.
        state_d    = RESP;
        rsp_data_d = err_q ? 32'h0 : sh_out;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset discards any operation in flight.
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= 5'h0;
      dat1_q       <= 32'h0;
      dat2_q       <= 32'h0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      rsp_data_q   <= 32'h0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dat1_q       <= dat1_d;
      dat2_q       <= dat2_d;
      id_q         <= id_d;
      err_q        <= err_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Shifter and response outputs are zero outside their own state.
  always_comb begin
    sh_dat_ready = (state_q == ISSUE) && !err_q;
    sh_dat1      = (state_q == ISSUE) ? dat1_q : 32'h0;
    sh_dat2      = (state_q == ISSUE) ? dat2_q : 32'h0;
    sh_instr     = (state_q == ISSUE) ? op_q   : 5'h0;
    rsp_valid    = (state_q == RESP);
    rsp_id       = (state_q == RESP) && id_q;
    rsp_err      = (state_q == RESP) && err_q;
    rsp_data     = (state_q == RESP) ? rsp_data_q : 32'h0;
    busy         = (state_q != IDLE);
  end

endmodule
